// File: rtl/apb3_slot_timeout_mux.sv
// apb3_slot_timeout_mux
// APB3 fan-out stage placed after the AHB-to-APB3 bridge. It decodes the bridge
// master port onto NUM_SLOTS peripheral slots and muxes the slot responses back
// to the bridge. A per-transfer watchdog ends any access that a slave stalls
// for TIMEOUT_CYCLES ACCESS cycles, with PSLVERR=1, so the bridge never hangs.
//
// Optional build macro: APB3_SLOT_QUARANTINE_EN
//   Adds CLR_QUAR. A slot that times out is quarantined: later accesses to it
//   get an immediate error response and never reach the slot, until its
//   CLR_QUAR bit is pulsed. A timeout and a clear in the same cycle leave the
//   slot quarantined.
//
// Ports
//   HCLK, HRESET                    clock and synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB3 request from the bridge
//   PRDATA/PREADY/PSLVERR           response to the bridge (combinational)
//   PSELS                           one-hot slot selects (combinational)
//   PENABLE_S/PWRITE_S/PADDR_S/PWDATA_S   request forwarded to all slots
//   PRDATA_S/PREADY_S/PSLVERR_S     per-slot responses, slot n data at
//                                   [n*DATA_WIDTH +: DATA_WIDTH]
//   CLR_QUAR                        quarantine clear, one bit per slot (macro only)
//   TIMEOUT_EVT                     one-cycle pulse after a timed-out completion
//   TIMEOUT_CNT                     saturating count of timeouts
//   LAST_TO_SLOT                    slot index of the most recent timeout
module apb3_slot_timeout_mux #(
    parameter int unsigned NUM_SLOTS      = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SLOT_SEL_LSB   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    input  logic                            PSEL,
    input  logic                            PENABLE,
    input  logic                            PWRITE,
    input  logic [ADDR_WIDTH-1:0]           PADDR,
    input  logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [DATA_WIDTH-1:0]           PRDATA,
    output logic                            PREADY,
    output logic                            PSLVERR,
    output logic [NUM_SLOTS-1:0]            PSELS,
    output logic                            PENABLE_S,
    output logic                            PWRITE_S,
    output logic [ADDR_WIDTH-1:0]           PADDR_S,
    output logic [DATA_WIDTH-1:0]           PWDATA_S,
    input  logic [NUM_SLOTS*DATA_WIDTH-1:0] PRDATA_S,
    input  logic [NUM_SLOTS-1:0]            PREADY_S,
    input  logic [NUM_SLOTS-1:0]            PSLVERR_S,
`ifdef APB3_SLOT_QUARANTINE_EN
    input  logic [NUM_SLOTS-1:0]            CLR_QUAR,
`endif
    output logic                            TIMEOUT_EVT,
    output logic [7:0]                      TIMEOUT_CNT,
    output logic [3:0]                      LAST_TO_SLOT
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]            state;
    logic [1:0]            stateNext;
    logic [WD_W-1:0]       wdCnt;
    logic [WD_W-1:0]       wdNext;
    logic [WD_W-1:0]       wdEff;
    logic [3:0]            idx;
    logic                  idxValid;
    logic                  blocked;
    logic                  slotReady;
    logic                  slotErr;
    logic [DATA_WIDTH-1:0] slotData;
    logic                  accessCycle;
    logic                  toFired;

`ifdef APB3_SLOT_QUARANTINE_EN
    logic [NUM_SLOTS-1:0]  quarMask;
    logic [NUM_SLOTS-1:0]  quarNext;
`endif

    // Slot decode and response select; looping avoids indexing past NUM_SLOTS
    always_comb begin
        idx       = PADDR[SLOT_SEL_LSB +: 4];
        idxValid  = ({1'b0, idx} < 5'(NUM_SLOTS));
        blocked   = 1'b0;
        slotReady = 1'b0;
        slotErr   = 1'b0;
        slotData  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx == 4'(i)) begin
                slotReady = PREADY_S[i];
                slotErr   = PSLVERR_S[i];
                slotData  = PRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef APB3_SLOT_QUARANTINE_EN
                blocked   = quarMask[i];
`endif
            end
        end
    end

    // Zero-latency forward path to the slots
    always_comb begin
        PSELS = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            PSELS[i] = PSEL & (idx == 4'(i)) & ~blocked;
        end
        PENABLE_S = PENABLE & ~toFired;
        PWRITE_S  = PWRITE;
        PADDR_S   = PADDR;
        PWDATA_S  = PWDATA;
    end

    // Next state, watchdog and bridge response
    always_comb begin
        stateNext = state;
        wdNext    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        toFired   = 1'b0;

        // PSEL&PENABLE straight out of IDLE is served as an ACCESS cycle
        accessCycle = PSEL & PENABLE;
        // The count only carries over between waited ACCESS cycles
        wdEff = (state == ACCESS) ? wdCnt : '0;

        if (accessCycle) begin
            if (!idxValid || blocked) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end else if (slotReady) begin
                PREADY  = 1'b1;
                PSLVERR = slotErr;
                PRDATA  = slotData;
            end else if (wdEff == WD_W'(TIMEOUT_CYCLES - 1)) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
                toFired = 1'b1;
            end else begin
                wdNext = (wdEff == '1) ? wdEff : wdEff + WD_W'(1);
            end
        end

        if (!PSEL) begin
            stateNext = IDLE;
        end else if (!PENABLE) begin
            stateNext = SETUP;
        end else if (PREADY) begin
            stateNext = IDLE;
        end else begin
            stateNext = ACCESS;
        end
    end

`ifdef APB3_SLOT_QUARANTINE_EN
    // Timeout sets the slot's bit after the clear so that set wins
    always_comb begin
        quarNext = quarMask & ~CLR_QUAR;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (toFired && (idx == 4'(i))) begin
                quarNext[i] = 1'b1;
            end
        end
    end
`endif

    // State, watchdog and timeout bookkeeping registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= IDLE;
            wdCnt        <= '0;
            TIMEOUT_EVT  <= 1'b0;
            TIMEOUT_CNT  <= 8'd0;
            LAST_TO_SLOT <= 4'd0;
`ifdef APB3_SLOT_QUARANTINE_EN
            quarMask     <= '0;
`endif
        end else begin
            state       <= stateNext;
            wdCnt       <= wdNext;
            TIMEOUT_EVT <= toFired;
            if (toFired) begin
                LAST_TO_SLOT <= idx;
                if (TIMEOUT_CNT != 8'hFF) begin
                    TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;
                end
            end
`ifdef APB3_SLOT_QUARANTINE_EN
            quarMask <= quarNext;
`endif
        end
    end

endmodule

// File: tb/tb_apb3_slot_timeout_mux.sv
// Testbench for apb3_slot_timeout_mux (NUM_SLOTS=4, TIMEOUT_CYCLES=16).
// A driver issues directed APB3 transfers and plays the slave side; each
// transfer queues its expected completion, which a negedge monitor checks.
module tb_apb3_slot_timeout_mux;

    logic         HCLK;
    logic         HRESET;
    logic         PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;
    logic [3:0]   PSELS;
    logic         PENABLE_S;
    logic         PWRITE_S;
    logic [31:0]  PADDR_S;
    logic [31:0]  PWDATA_S;
    logic [127:0] PRDATA_S;
    logic [3:0]   PREADY_S;
    logic [3:0]   PSLVERR_S;
`ifdef APB3_SLOT_QUARANTINE_EN
    logic [3:0]   CLR_QUAR;
`endif
    logic         TIMEOUT_EVT;
    logic [7:0]   TIMEOUT_CNT;
    logic [3:0]   LAST_TO_SLOT;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [3:0]  psels;
        logic        penS;
        logic [7:0]  cycles;
    } exp_t;

    exp_t     expQ[$];
    int       checks = 0;
    int       errors = 0;
    int       expCnt = 0;
    logic [7:0] accCnt = 8'd0;

    apb3_slot_timeout_mux #(
        .NUM_SLOTS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .SLOT_SEL_LSB(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .PSELS(PSELS), .PENABLE_S(PENABLE_S), .PWRITE_S(PWRITE_S),
        .PADDR_S(PADDR_S), .PWDATA_S(PWDATA_S),
        .PRDATA_S(PRDATA_S), .PREADY_S(PREADY_S), .PSLVERR_S(PSLVERR_S),
`ifdef APB3_SLOT_QUARANTINE_EN
        .CLR_QUAR(CLR_QUAR),
`endif
        .TIMEOUT_EVT(TIMEOUT_EVT), .TIMEOUT_CNT(TIMEOUT_CNT),
        .LAST_TO_SLOT(LAST_TO_SLOT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    // Completion monitor: pops one expectation per PREADY in an ACCESS cycle
    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESET && PSEL && PENABLE) begin
            accCnt = accCnt + 8'd1;
            if (PREADY) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_completion: got PREADY=1 addr=%h, required no completion", PADDR);
                end else begin
                    e = expQ.pop_front();
                    if ({PRDATA, PSLVERR, PSELS, PENABLE_S, accCnt} !== e) begin
                        errors++;
                        $display("FAIL completion addr=%h: got data=%h err=%b psels=%b penS=%b cyc=%0d, required data=%h err=%b psels=%b penS=%b cyc=%0d",
                                 PADDR, PRDATA, PSLVERR, PSELS, PENABLE_S, accCnt,
                                 e.data, e.err, e.psels, e.penS, e.cycles);
                    end
                end
                accCnt = 8'd0;
            end
        end else begin
            accCnt = 8'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic clrQuar(input logic [3:0] mask);
`ifdef APB3_SLOT_QUARANTINE_EN
        @(posedge HCLK); #1 CLR_QUAR = mask;
        @(posedge HCLK); #1 CLR_QUAR = 4'b0000;
`else
        if (mask != 4'b0000) @(posedge HCLK);
`endif
    endtask

    // One APB3 transfer. readyAt: ACCESS cycle (1-based) in which the slot
    // raises PREADY_S, 0 = never.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int readyAt, input logic sErr, input logic [31:0] sData,
                        input logic [3:0] expPsels, input logic [31:0] expData,
                        input logic expErr, input logic [7:0] expCyc, input logic expTo);
        int   slot;
        int   cyc;
        logic done;
        slot = int'(addr[11:8]);
        expQ.push_back({expData, expErr, expPsels, ~expTo, expCyc});
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        PREADY_S = 4'b0000; PSLVERR_S = 4'b0000;
        @(negedge HCLK);
        checks++;
        if (PREADY !== 1'b0 || PSELS !== expPsels || PWRITE_S !== wr ||
            PADDR_S !== addr || PWDATA_S !== wdata) begin
            errors++;
            $display("FAIL setup addr=%h: got ready=%b psels=%b pwrite=%b paddr=%h pwdata=%h, required ready=0 psels=%b pwrite=%b paddr=%h pwdata=%h",
                     addr, PREADY, PSELS, PWRITE_S, PADDR_S, PWDATA_S, expPsels, wr, addr, wdata);
        end
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        cyc  = 1;
        done = 1'b0;
        while (!done) begin
            if (slot < 4) begin
                PREADY_S[slot]             = (readyAt == cyc);
                PSLVERR_S[slot]            = sErr;
                PRDATA_S[slot*32 +: 32]    = sData;
            end
            @(negedge HCLK);
            done = PREADY;
            @(posedge HCLK); #1;
            if (!done) begin
                cyc++;
                if (cyc > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL bound addr=%h: got no PREADY in 40 cycles, required completion", addr);
                    done = 1'b1;
                end
            end
        end
        PSEL = 1'b0; PENABLE = 1'b0; PREADY_S = 4'b0000; PSLVERR_S = 4'b0000;
        chk("timeout_evt", 32'(TIMEOUT_EVT), 32'(expTo));
    endtask

    initial begin
        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PRDATA_S = '0; PREADY_S = '0; PSLVERR_S = '0;
`ifdef APB3_SLOT_QUARANTINE_EN
        CLR_QUAR = 4'b0000;
`endif
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_psels", 32'(PSELS), 32'd0);
        chk("rst_evt", 32'(TIMEOUT_EVT), 32'd0);
        chk("rst_cnt", 32'(TIMEOUT_CNT), 32'd0);
        chk("rst_last", 32'(LAST_TO_SLOT), 32'd0);
        HRESET = 1'b0;

        // write slot 2, ready at once
        xfer(1'b1, 32'h0000_0200, 32'hA5A5_0001, 1, 1'b0, 32'h0, 4'b0100, 32'h0, 1'b0, 8'd1, 1'b0);
        // read slot 1 with three wait states
        xfer(1'b0, 32'h0000_0100, 32'h0, 4, 1'b0, 32'h1234_5678, 4'b0010, 32'h1234_5678, 1'b0, 8'd4, 1'b0);
        // slot 3 never ready: timeout in ACCESS cycle 16
        xfer(1'b0, 32'h0000_0300, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 4'b1000, 32'h0, 1'b1, 8'd16, 1'b1);
        expCnt++;
        chk("cnt_after_to", 32'(TIMEOUT_CNT), 32'd1);
        chk("last_after_to", 32'(LAST_TO_SLOT), 32'd3);
        @(posedge HCLK); #1;
        chk("evt_one_cycle", 32'(TIMEOUT_EVT), 32'd0);
        // unmapped slot 7
        xfer(1'b0, 32'h0000_0700, 32'h0, 1, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 8'd1, 1'b0);
        // slot 0 ready exactly in cycle 16 with slave error: normal completion
        xfer(1'b0, 32'h0000_0000, 32'h0, 16, 1'b1, 32'hCAFE_0000, 4'b0001, 32'hCAFE_0000, 1'b1, 8'd16, 1'b0);
        chk("cnt_ready_at_16", 32'(TIMEOUT_CNT), 32'd1);
        chk("last_ready_at_16", 32'(LAST_TO_SLOT), 32'd3);
        // write slot 2 ready in cycle 15
        xfer(1'b1, 32'h0000_0204, 32'h0BAD_0BAD, 15, 1'b0, 32'h0BAD_0BAD, 4'b0100, 32'h0BAD_0BAD, 1'b0, 8'd15, 1'b0);

`ifdef APB3_SLOT_QUARANTINE_EN
        clrQuar(4'b1111);
        xfer(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0, 32'h0, 4'b0001, 32'h0, 1'b1, 8'd16, 1'b1);
        expCnt++;
        chk("quar_last", 32'(LAST_TO_SLOT), 32'd0);
        xfer(1'b0, 32'h0000_0000, 32'h0, 1, 1'b0, 32'h55, 4'b0000, 32'h0, 1'b1, 8'd1, 1'b0);
        clrQuar(4'b0001);
        xfer(1'b0, 32'h0000_0000, 32'h0, 1, 1'b0, 32'h55, 4'b0001, 32'h55, 1'b0, 8'd1, 1'b0);
`endif

        // 300 more timeouts: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            clrQuar(4'b1000);
            xfer(1'b0, 32'h0000_0300, 32'h0, 0, 1'b0, 32'h0, 4'b1000, 32'h0, 1'b1, 8'd16, 1'b1);
            expCnt++;
            if (i == 9) chk("cnt_mid", 32'(TIMEOUT_CNT), 32'(expCnt));
        end
        chk("cnt_saturated", 32'(TIMEOUT_CNT), 32'd255);
        chk("last_saturated", 32'(LAST_TO_SLOT), 32'd3);

        // reset clears the timeout bookkeeping
        @(posedge HCLK); #1 HRESET = 1'b1;
        @(posedge HCLK); #1;
        chk("rst2_cnt", 32'(TIMEOUT_CNT), 32'd0);
        chk("rst2_last", 32'(LAST_TO_SLOT), 32'd0);
        chk("rst2_evt", 32'(TIMEOUT_EVT), 32'd0);
        HRESET = 1'b0;

        repeat (2) @(posedge HCLK);
        #1;
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
